// File: rtl/mem_stage_if.sv
`default_nettype none
// =====================================================================
// mem_stage_if : req/ack data-memory port between mem_stage and memory
// Rev 1.0
// =====================================================================
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// =====================================================================
// mem_stage : pipeline memory-access stage, LW/SW over req/ack port
// Rev 1.0
// =====================================================================
module mem_stage #(
  parameter logic [5:0]  OP_LW   = 6'h23,
  parameter logic [5:0]  OP_SW   = 6'h2B,
  parameter int unsigned TIMEOUT = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [5:0]  op_mem_i,
  input  wire logic [31:0] alu_mem_i,
  input  wire logic [31:0] addr_mem_i,
  input  wire logic [4:0]  Ri_mem_i,
  mem_stage_if.master      dm,
  output logic             stall_o,
  output logic [5:0]       op_wb_o,
  output logic [31:0]      data_wb_o,
  output logic [4:0]       Ri_wb_o,
  output logic             wen_wb_o,
  output logic             mem_err_o
);

  localparam int unsigned c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic                dm_req_q;
  logic                dm_we_q;
  logic [31:0]         dm_addr_q;
  logic [31:0]         dm_wdata_q;
  logic [31:0]         rdata_q;
  logic [c_cnt_w-1:0]  cnt_q;
  logic                err_q;
  logic [5:0]          op_wb_q;
  logic [31:0]         data_wb_q;
  logic [4:0]          Ri_wb_q;
  logic                wen_wb_q;
  logic                mem_err_q;

  logic w_is_mem;
  logic w_misalign;
  logic w_writes;

  assign w_is_mem   = (op_mem_i == OP_LW) || (op_mem_i == OP_SW);
  assign w_misalign = |addr_mem_i[1:0];
  assign w_writes   = !((op_mem_i == OP_SW) || (op_mem_i == 6'h04) ||
                        (op_mem_i == 6'h05) || (op_mem_i == 6'h02)) &&
                      (Ri_mem_i != 5'd0);

  // The held memory instruction retires in DONE, so only IDLE-with-mem and REQ stall.
  assign stall_o = (state_q == S_REQ) || ((state_q == S_IDLE) && w_is_mem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      op_wb_q    <= '0;
      data_wb_q  <= '0;
      Ri_wb_q    <= '0;
      wen_wb_q   <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      op_wb_q   <= '0;
      data_wb_q <= '0;
      Ri_wb_q   <= '0;
      wen_wb_q  <= 1'b0;
      mem_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_is_mem) begin
            // Cleared so a failed load retires with zero data.
            rdata_q <= '0;
            if (w_misalign) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dm_req_q   <= 1'b1;
              dm_we_q    <= (op_mem_i == OP_SW);
              dm_addr_q  <= addr_mem_i;
              dm_wdata_q <= alu_mem_i;
              cnt_q      <= '0;
              state_q    <= S_REQ;
            end
          end else begin
            op_wb_q   <= op_mem_i;
            data_wb_q <= alu_mem_i;
            Ri_wb_q   <= Ri_mem_i;
            wen_wb_q  <= w_writes;
          end
        end
        S_REQ: begin
          if (dm.dm_ack) begin
            rdata_q  <= dm.dm_rdata;
            dm_req_q <= 1'b0;
            state_q  <= S_DONE;
          end else if (cnt_q == c_tmo_last) begin
            dm_req_q <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + c_cnt_one;
          end
        end
        S_DONE: begin
          op_wb_q   <= op_mem_i;
          Ri_wb_q   <= Ri_mem_i;
          data_wb_q <= (op_mem_i == OP_LW) ? rdata_q : 32'h0;
          wen_wb_q  <= w_writes && !err_q;
          mem_err_q <= err_q;
          err_q     <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_wdata = dm_wdata_q;

  assign op_wb_o   = op_wb_q;
  assign data_wb_o = data_wb_q;
  assign Ri_wb_o   = Ri_wb_q;
  assign wen_wb_o  = wen_wb_q;
  assign mem_err_o = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// =====================================================================
// tb_mem_stage : directed bench for mem_stage with a cycle predictor
// Rev 1.0
// =====================================================================
module tb_mem_stage;

  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2B;
  localparam int         TMO = 16;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op;
  logic [31:0] alu;
  logic [31:0] addr;
  logic [4:0]  ri;
  logic        stall;
  logic [5:0]  op_wb;
  logic [31:0] data_wb;
  logic [4:0]  ri_wb;
  logic        wen_wb;
  logic        mem_err;

  mem_stage_if dm_bus ();

  mem_stage #(.OP_LW(LW), .OP_SW(SW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_mem_i   (op),
    .alu_mem_i  (alu),
    .addr_mem_i (addr),
    .Ri_mem_i   (ri),
    .dm         (dm_bus),
    .stall_o    (stall),
    .op_wb_o    (op_wb),
    .data_wb_o  (data_wb),
    .Ri_wb_o    (ri_wb),
    .wen_wb_o   (wen_wb),
    .mem_err_o  (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_mem(input logic [5:0] o);
    return (o == LW) || (o == SW);
  endfunction

  function automatic bit writes(input logic [5:0] o, input logic [4:0] r);
    return !(o inside {SW, 6'h04, 6'h05, 6'h02}) && (r != 5'd0);
  endfunction

  // Memory responder: acks on the ack_lat-th request cycle (0 = never).
  int          ack_lat  = 0;
  bit          spur     = 1'b0;
  logic [31:0] rd_val   = '0;
  int          req_seen = 0;

  always @(posedge clk) begin
    #1;
    if (dm_bus.dm_req) begin
      req_seen++;
      dm_bus.dm_ack   = (ack_lat != 0) && (req_seen == ack_lat);
      dm_bus.dm_rdata = dm_bus.dm_ack ? rd_val : 32'h0;
    end else begin
      req_seen = 0;
      dm_bus.dm_ack   = spur;
      dm_bus.dm_rdata = spur ? 32'hBAD0BAD0 : 32'h0;
    end
  end

  // Predictor: one pending transaction, described by what it still owes.
  bit          chk_en = 1'b0;
  bit          e_req;
  bit          e_done;
  bit          e_bad;
  int          e_age;
  bit          e_we;
  logic [31:0] e_addr, e_wdata, e_cap;
  logic [5:0]  e_op;
  logic [31:0] e_data;
  logic [4:0]  e_ri;
  bit          e_wen, e_err;

  task automatic model_clear();
    e_req = 0; e_done = 0; e_bad = 0; e_age = 0; e_we = 0;
    e_addr = '0; e_wdata = '0; e_cap = '0;
    e_op = '0; e_data = '0; e_ri = '0; e_wen = 0; e_err = 0;
  endtask

  task automatic model_advance();
    e_op = '0; e_data = '0; e_ri = '0; e_wen = 0; e_err = 0;
    if (e_done) begin
      e_op   = op;
      e_ri   = ri;
      e_data = (op == LW) ? e_cap : 32'h0;
      e_wen  = writes(op, ri) && !e_bad;
      e_err  = e_bad;
      e_done = 0;
      e_bad  = 0;
    end else if (e_req) begin
      e_age++;
      if (dm_bus.dm_ack) begin
        e_cap = dm_bus.dm_rdata; e_req = 0; e_done = 1;
      end else if (e_age == TMO) begin
        e_req = 0; e_done = 1; e_bad = 1;
      end
    end else if (is_mem(op)) begin
      e_cap = '0;
      if (addr[1:0] != 2'b00) begin
        e_done = 1; e_bad = 1;
      end else begin
        e_req = 1; e_age = 0; e_we = (op == SW); e_addr = addr; e_wdata = alu;
      end
    end else begin
      e_op = op; e_data = alu; e_ri = ri; e_wen = writes(op, ri);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) model_clear();
      chk("stall", 32'(stall), 32'(e_req || (!e_req && !e_done && is_mem(op))));
      chk("dm_req", 32'(dm_bus.dm_req), 32'(e_req));
      if (e_req || !rst_n) begin
        chk("dm_we", 32'(dm_bus.dm_we), 32'(e_we));
        chk("dm_addr", dm_bus.dm_addr, e_addr);
        chk("dm_wdata", dm_bus.dm_wdata, e_wdata);
      end
      chk("op_wb", 32'(op_wb), 32'(e_op));
      chk("data_wb", data_wb, e_data);
      chk("Ri_wb", 32'(ri_wb), 32'(e_ri));
      chk("wen_wb", 32'(wen_wb), 32'(e_wen));
      chk("mem_err", 32'(mem_err), 32'(e_err));
      if (rst_n) model_advance();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    op = 6'h00; alu = '0; addr = '0; ri = '0;
  endtask

  task automatic alu_op(input logic [5:0] o, input logic [31:0] a, input logic [4:0] r);
    op = o; alu = a; addr = '0; ri = r;
    step();
  endtask

  // Presents a memory op, holds it while stalled, returns at WB-valid time.
  task automatic mem_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] r, input int lat, input logic [31:0] rv,
                        output int n_stall, output int n_req,
                        output logic [31:0] f_addr, output logic f_we, output logic [31:0] f_wd);
    ack_lat = lat; rd_val = rv;
    op = o; addr = a; alu = d; ri = r;
    n_stall = 0; n_req = 0; f_addr = '0; f_we = 1'b0; f_wd = '0;
    #1;
    while (stall && n_stall < 100) begin
      n_stall++;
      step();
      if (dm_bus.dm_req) begin
        n_req++;
        if (n_req == 1) begin
          f_addr = dm_bus.dm_addr; f_we = dm_bus.dm_we; f_wd = dm_bus.dm_wdata;
        end
      end
    end
    if (n_stall >= 100) chk("stall_bound", 32'(n_stall), 32'd0);
    step();
    nop();
  endtask

  int          ns, nr;
  logic [31:0] fa, fw;
  logic        fe;

  initial begin
    rst_n = 1'b0;
    nop();
    dm_bus.dm_ack = 1'b0;
    dm_bus.dm_rdata = '0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
    chk("rst_wen", 32'(wen_wb), 32'd0);
    chk("rst_data", data_wb, 32'd0);
    rst_n = 1'b1;

    alu_op(6'h00, 32'h11, 5'd4);
    chk("alu_data", data_wb, 32'h11);
    chk("alu_wen", 32'(wen_wb), 32'd1);

    mem_op(LW, 32'h100, 32'h0, 5'd8, 3, 32'hDEADBEEF, ns, nr, fa, fe, fw);
    chk("lw_stall", 32'(ns), 32'd4);
    chk("lw_req", 32'(nr), 32'd3);
    chk("lw_addr", fa, 32'h100);
    chk("lw_we", 32'(fe), 32'd0);
    chk("lw_data", data_wb, 32'hDEADBEEF);
    chk("lw_ri", 32'(ri_wb), 32'd8);
    chk("lw_wen", 32'(wen_wb), 32'd1);

    mem_op(SW, 32'h204, 32'h12345678, 5'd5, 1, 32'h0, ns, nr, fa, fe, fw);
    chk("sw_stall", 32'(ns), 32'd2);
    chk("sw_we", 32'(fe), 32'd1);
    chk("sw_wdata", fw, 32'h12345678);
    chk("sw_wen", 32'(wen_wb), 32'd0);

    mem_op(LW, 32'h102, 32'h0, 5'd9, 1, 32'h0, ns, nr, fa, fe, fw);
    chk("mis_stall", 32'(ns), 32'd1);
    chk("mis_req", 32'(nr), 32'd0);
    chk("mis_err", 32'(mem_err), 32'd1);
    chk("mis_wen", 32'(wen_wb), 32'd0);
    step();
    chk("mis_err_pulse", 32'(mem_err), 32'd0);

    mem_op(LW, 32'h300, 32'h0, 5'd7, 0, 32'h0, ns, nr, fa, fe, fw);
    chk("tmo_req", 32'(nr), 32'd16);
    chk("tmo_stall", 32'(ns), 32'd17);
    chk("tmo_err", 32'(mem_err), 32'd1);
    chk("tmo_wen", 32'(wen_wb), 32'd0);

    mem_op(LW, 32'h40, 32'h0, 5'd2, 2, 32'hCAFEF00D, ns, nr, fa, fe, fw);
    chk("after_tmo_data", data_wb, 32'hCAFEF00D);
    chk("after_tmo_wen", 32'(wen_wb), 32'd1);
    chk("after_tmo_err", 32'(mem_err), 32'd0);

    spur = 1'b1;
    step();
    alu_op(6'h00, 32'h77, 5'd0);
    chk("r0_wen", 32'(wen_wb), 32'd0);
    alu_op(6'h04, 32'h1, 5'd6);
    chk("beq_wen", 32'(wen_wb), 32'd0);
    chk("beq_op", 32'(op_wb), 32'h04);
    alu_op(6'h08, 32'hAB, 5'd10);
    chk("spur_dm_req", 32'(dm_bus.dm_req), 32'd0);
    chk("addi_data", data_wb, 32'hAB);
    spur = 1'b0;
    nop();
    step();

    ack_lat = 0;
    op = LW; addr = 32'h500; alu = '0; ri = 5'd3;
    repeat (3) step();
    chk("mid_req_high", 32'(dm_bus.dm_req), 32'd1);
    rst_n = 1'b0;
    nop();
    #1;
    chk("async_dm_req", 32'(dm_bus.dm_req), 32'd0);
    chk("async_stall", 32'(stall), 32'd0);
    chk("async_addr", dm_bus.dm_addr, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    alu_op(6'h00, 32'h5, 5'd3);
    chk("post_rst_data", data_wb, 32'h5);
    chk("post_rst_wen", 32'(wen_wb), 32'd1);
    nop();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
